// File: rtl/frame_disassembler_pkg.sv
// Receive/transmit frame geometry and the disassembler FSM state encoding.
package frame_disassembler_pkg;

  localparam int FFT_POINT  = 64;
  localparam int CP_NUM     = 16;
  localparam int SYMBOL_NUM = 8;
  localparam int SYNC_LEN   = 480;
  localparam int SYM_LEN    = FFT_POINT + CP_NUM;
  localparam int FRAME_LEN  = SYNC_LEN + SYMBOL_NUM * SYM_LEN;
  localparam int CNT_W      = $clog2(SYNC_LEN + 1);
  localparam int SYM_W      = $clog2(SYMBOL_NUM);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP_SYNC,
    ST_SKIP_CP,
    ST_DATA
  } fd_state_t;

endpackage

// File: rtl/frame_disassembler.sv
// Strips preamble and cyclic prefix, streams FFT windows; 1-cycle registered latency, no backpressure.
// Define FRAME_DISASM_KEEP_CP_EN to forward the cyclic prefix along with each window.
module frame_disassembler
  import frame_disassembler_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    din,
  input  logic             din_valid,
  input  logic             sync_found,
  output logic [DW-1:0]    dout,
  output logic             dout_valid,
  output logic [SYM_W-1:0] sym_idx,
  output logic             sym_first,
  output logic             sym_last,
  output logic             frame_done,
  output logic             frame_abort,
  output logic             busy
);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] CP_LAST   = CNT_W'(CP_NUM - 1);
  localparam logic [CNT_W-1:0] FFT_LAST  = CNT_W'(FFT_POINT - 1);
  localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(SYMBOL_NUM - 1);

  fd_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SYM_W-1:0] sym, sym_nxt;
  logic             fwd, fwd_first, fwd_last, done, abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      sym         <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      sym_idx     <= '0;
      sym_first   <= 1'b0;
      sym_last    <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      sym         <= sym_nxt;
      dout_valid  <= fwd;
      sym_first   <= fwd_first;
      sym_last    <= fwd_last;
      frame_done  <= done;
      frame_abort <= abort;
      // busy stays up through the frame_done cycle
      busy        <= (state_nxt != ST_IDLE) || done;
      if (fwd) begin
        dout    <= din;
        sym_idx <= sym;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sym_nxt   = sym;
    fwd       = 1'b0;
    fwd_first = 1'b0;
    fwd_last  = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    if (din_valid && sync_found) begin
      abort     = (state != ST_IDLE);
      state_nxt = ST_SKIP_SYNC;
      cnt_nxt   = CNT_W'(1);
      sym_nxt   = '0;
      // the final data sample of a frame is still delivered on a coincident resync
      if (state == ST_DATA && cnt == FFT_LAST && sym == SYM_LAST) begin
        fwd      = 1'b1;
        fwd_last = 1'b1;
      end
    end else if (din_valid) begin
      unique case (state)
        ST_IDLE: ;
        ST_SKIP_SYNC: begin
          if (cnt == SYNC_LAST) begin
            state_nxt = ST_SKIP_CP;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        ST_SKIP_CP: begin
`ifdef FRAME_DISASM_KEEP_CP_EN
          fwd       = 1'b1;
          fwd_first = (cnt == '0);
`endif
          if (cnt == CP_LAST) begin
            state_nxt = ST_DATA;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        ST_DATA: begin
          fwd = 1'b1;
`ifndef FRAME_DISASM_KEEP_CP_EN
          fwd_first = (cnt == '0);
`endif
          if (cnt == FFT_LAST) begin
            fwd_last = 1'b1;
            cnt_nxt  = '0;
            if (sym == SYM_LAST) begin
              done      = 1'b1;
              state_nxt = ST_IDLE;
              sym_nxt   = '0;
            end else begin
              sym_nxt   = sym + 1'b1;
              state_nxt = ST_SKIP_CP;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule
